// File: rtl/init_seq_pkg.sv
// Shared types and elaboration helpers for the power-up sequencer.
// Imported by the sequencer top and its timer.
package init_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    // Internal stage index width: enough to address the largest supported chain (8 stages).
    localparam int STAGE_W = 3;
    localparam int RETRY_W = 3;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int     bits;
        longint span;
        bits = 0;
        span = 1;
        while (span < longint'(value)) begin
            span = span * 2;
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/init_seq_timer.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
// A limit of zero reports terminal count on every cycle (pass-through).
module init_seq_timer
    import init_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (limit == '0) || (count_q == (limit - W'(1)));

endmodule

// File: rtl/init_sequencer.sv
// Power-up sequencer: releases stage enables in order, waits for each done flag,
// retries a stage on timeout and latches a failure once retries are exhausted.
module init_sequencer
    import init_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 27000000,
    parameter int SETTLE_CYCLES  = 270,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          restart,
    input  logic [NUM_STAGES-1:0]         stage_done,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [$clog2(NUM_STAGES)-1:0] bus_owner,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic [NUM_STAGES-1:0]         progress,
    output logic [2:0]                    retry_cnt,
    output logic                          all_done,
    output logic                          error,
    output logic [$clog2(NUM_STAGES)-1:0] error_stage
);

    localparam int  IDX_W      = $clog2(NUM_STAGES);
    localparam int  TMR_W      = clog2_min1(max2(TIMEOUT_CYCLES, SETTLE_CYCLES) + 1);
    localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t               state_q, state_d;
    logic [STAGE_W-1:0]   idx_q, idx_d;
    logic [RETRY_W-1:0]   retries_q, retries_d;
    logic [NUM_STAGES-1:0] en_q, en_d;
    logic [NUM_STAGES-1:0] prog_q, prog_d;

    logic [NUM_STAGES-1:0] sel;
    logic                  done_hit;
    logic                  last_stage;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic [TMR_W-1:0]      tmr_limit;
    logic                  tmr_tc;
    logic                  timeout_hit;

    // One-hot view of the current stage; only that stage's done flag is honoured.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
        assign sel[gi] = (idx_q == STAGE_W'(gi));
    end

    assign done_hit    = |(stage_done & sel);
    assign last_stage  = (idx_q == STAGE_W'(NUM_STAGES - 1));
    assign tmr_en      = (state_q == ST_SETTLE) || (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign tmr_limit   = (state_q == ST_RUN) ? TMR_W'(TIMEOUT_CYCLES) : TMR_W'(SETTLE_CYCLES);
    assign timeout_hit = TIMEOUT_EN && tmr_tc;

    init_seq_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retries_d = retries_q;
        en_d      = en_q;
        prog_d    = prog_q;

        if (restart && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            retries_d = '0;
            en_d      = '0;
            prog_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_SETTLE;
                        idx_d     = '0;
                        retries_d = '0;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_tc) begin
                        en_d    = en_q | sel;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A done flag on the timeout cycle still counts as success.
                    if (done_hit) begin
                        prog_d    = prog_q | sel;
                        retries_d = '0;
                        if (last_stage) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + STAGE_W'(1);
                            state_d = ST_SETTLE;
                        end
                    end else if (timeout_hit) begin
                        en_d = en_q & ~sel;
                        if (retries_q < RETRY_W'(MAX_RETRIES)) begin
                            retries_d = retries_q + RETRY_W'(1);
                            state_d   = ST_HOLD;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_tc) begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_DONE, ST_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Every phase change restarts the shared timer from zero.
    assign tmr_clr = (state_d != state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            retries_q <= '0;
            en_q      <= '0;
            prog_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retries_q <= retries_d;
            en_q      <= en_d;
            prog_q    <= prog_d;
        end
    end

    assign stage_en    = en_q;
    assign progress    = prog_q;
    assign retry_cnt   = retries_q;
    assign all_done    = (state_q == ST_DONE);
    assign error       = (state_q == ST_FAIL);
    assign error_stage = (state_q == ST_FAIL) ? idx_q[IDX_W-1:0] : '0;
    assign cur_stage   = (state_q == ST_IDLE) ? '0 : idx_q[IDX_W-1:0];
    assign bus_owner   = (state_q == ST_IDLE) ? '0 :
                         (state_q == ST_DONE) ? IDX_W'(NUM_STAGES - 1) : idx_q[IDX_W-1:0];

endmodule

// File: tb/tb_init_sequencer.sv
// Self-checking bench: timeline vector tables per scenario feed a scoreboard queue,
// plus a hand-written asynchronous reset sequence.
module tb_init_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: 3 stages, settle 4, timeout 20, one retry
    logic       a_start = 1'b0, a_restart = 1'b0;
    logic [2:0] a_done = '0;
    logic [2:0] a_en, a_prog, a_retry;
    logic [1:0] a_bus, a_cur, a_es;
    logic       a_all, a_err;

    // DUT B: 4 stages, settle 0, timeout disabled
    logic       b_start = 1'b0, b_restart = 1'b0;
    logic [3:0] b_done = '0;
    logic [3:0] b_en, b_prog;
    logic [2:0] b_retry;
    logic [1:0] b_bus, b_cur, b_es;
    logic       b_all, b_err;

    init_sequencer #(.NUM_STAGES(3), .TIMEOUT_CYCLES(20), .SETTLE_CYCLES(4), .MAX_RETRIES(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .restart(a_restart), .stage_done(a_done),
        .stage_en(a_en), .bus_owner(a_bus), .cur_stage(a_cur), .progress(a_prog),
        .retry_cnt(a_retry), .all_done(a_all), .error(a_err), .error_stage(a_es)
    );

    init_sequencer #(.NUM_STAGES(4), .TIMEOUT_CYCLES(0), .SETTLE_CYCLES(0), .MAX_RETRIES(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .restart(b_restart), .stage_done(b_done),
        .stage_en(b_en), .bus_owner(b_bus), .cur_stage(b_cur), .progress(b_prog),
        .retry_cnt(b_retry), .all_done(b_all), .error(b_err), .error_stage(b_es)
    );

    // Observation bundle: {en, prog, all_done, error, error_stage, cur_stage, bus_owner, retry}
    typedef logic [18:0] obs_t;

    function automatic obs_t mk(input logic [3:0] en, input logic [3:0] prog, input logic ad,
                                input logic er, input logic [1:0] es, input logic [1:0] cur,
                                input logic [1:0] bus, input logic [2:0] rt);
        return {en, prog, ad, er, es, cur, bus, rt};
    endfunction

    obs_t obs_a, obs_b;
    assign obs_a = {1'b0, a_en, 1'b0, a_prog, a_all, a_err, a_es, a_cur, a_bus, a_retry};
    assign obs_b = {b_en, b_prog, b_all, b_err, b_es, b_cur, b_bus, b_retry};

    typedef struct {
        int         scn;
        int         dut;
        int         cyc;
        logic       start;
        logic       restart;
        logic [3:0] done;
        obs_t       exp;
    } vec_t;

    typedef struct {
        int   idx;
        int   dut;
        obs_t exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   cur = 0;

    task automatic add(input int scn, input int dut, input int cyc, input logic st,
                       input logic rs, input logic [3:0] dn, input obs_t exp);
        vec_t v;
        v.scn = scn; v.dut = dut; v.cyc = cyc; v.start = st; v.restart = rs; v.done = dn; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(negedge clk);
        cur++;
    endtask

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%05h required=%05h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic do_reset();
        a_start = 1'b0; a_restart = 1'b0; a_done = '0;
        b_start = 1'b0; b_restart = 1'b0; b_done = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: compares every pending expectation just after the falling edge.
    initial begin
        sb_t  e;
        obs_t act;
        forever begin
            @(negedge clk);
            #1;
            while (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = (e.dut == 0) ? obs_a : obs_b;
                checks++;
                if (act !== e.exp) begin
                    $display("FAIL vec%0d scn%0d cyc%0d: actual=%05h required=%05h",
                             e.idx, vecs[e.idx].scn, vecs[e.idx].cyc, act, e.exp);
                end else begin
                    passes++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        obs_t z;
        z = '0;

        // Scenario 0: nominal bring-up of all three stages, then restart to idle
        add(0, 0,  0, 1, 0, 4'h0, z);
        add(0, 0,  1, 1, 0, 4'h0, z);
        add(0, 0,  4, 1, 0, 4'h0, z);
        add(0, 0,  5, 1, 0, 4'h0, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(0, 0,  8, 1, 0, 4'h1, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(0, 0,  9, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 12, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 13, 1, 0, 4'h1, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 16, 1, 0, 4'h3, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 17, 1, 0, 4'h3, mk(4'h3, 4'h3, 0, 0, 0, 2, 2, 0));
        add(0, 0, 20, 1, 0, 4'h3, mk(4'h3, 4'h3, 0, 0, 0, 2, 2, 0));
        add(0, 0, 21, 1, 0, 4'h3, mk(4'h7, 4'h3, 0, 0, 0, 2, 2, 0));
        add(0, 0, 24, 1, 0, 4'h7, mk(4'h7, 4'h3, 0, 0, 0, 2, 2, 0));
        add(0, 0, 25, 1, 0, 4'h7, mk(4'h7, 4'h7, 1, 0, 0, 2, 2, 0));
        add(0, 0, 30, 0, 0, 4'h7, mk(4'h7, 4'h7, 1, 0, 0, 2, 2, 0));
        add(0, 0, 31, 0, 1, 4'h7, mk(4'h7, 4'h7, 1, 0, 0, 2, 2, 0));
        add(0, 0, 32, 0, 0, 4'h0, z);
        add(0, 0, 34, 0, 0, 4'h0, z);

        // Scenario 1: stage 1 never completes -> one retry then failure
        add(1, 0,  0, 1, 0, 4'h0, z);
        add(1, 0,  5, 1, 0, 4'h0, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(1, 0,  8, 1, 0, 4'h1, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(1, 0,  9, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 0));
        add(1, 0, 13, 1, 0, 4'h1, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 0));
        add(1, 0, 32, 1, 0, 4'h1, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 0));
        add(1, 0, 33, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 1));
        add(1, 0, 36, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 1));
        add(1, 0, 37, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 1));
        add(1, 0, 40, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 1));
        add(1, 0, 41, 1, 0, 4'h1, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 1));
        add(1, 0, 60, 1, 0, 4'h1, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 1));
        add(1, 0, 61, 1, 0, 4'h1, mk(4'h1, 4'h1, 0, 1, 1, 1, 1, 1));
        add(1, 0, 70, 0, 0, 4'h1, mk(4'h1, 4'h1, 0, 1, 1, 1, 1, 1));
        add(1, 0, 71, 0, 1, 4'h1, mk(4'h1, 4'h1, 0, 1, 1, 1, 1, 1));
        add(1, 0, 72, 0, 0, 4'h0, z);

        // Scenario 2: done on the exact timeout cycle, then restart during stage 2 RUN
        add(2, 0,  0, 1, 0, 4'h0, z);
        add(2, 0,  5, 1, 0, 4'h0, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(2, 0, 23, 1, 0, 4'h0, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(2, 0, 24, 1, 0, 4'h1, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(2, 0, 25, 1, 0, 4'h0, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 0));
        add(2, 0, 28, 1, 0, 4'h0, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 0));
        add(2, 0, 29, 1, 0, 4'h0, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 0));
        add(2, 0, 32, 1, 0, 4'h2, mk(4'h3, 4'h1, 0, 0, 0, 1, 1, 0));
        add(2, 0, 33, 1, 0, 4'h2, mk(4'h3, 4'h3, 0, 0, 0, 2, 2, 0));
        add(2, 0, 37, 1, 0, 4'h2, mk(4'h7, 4'h3, 0, 0, 0, 2, 2, 0));
        add(2, 0, 39, 1, 1, 4'h0, mk(4'h7, 4'h3, 0, 0, 0, 2, 2, 0));
        add(2, 0, 40, 1, 0, 4'h0, z);
        add(2, 0, 41, 1, 0, 4'h0, z);
        add(2, 0, 44, 1, 0, 4'h0, z);
        add(2, 0, 45, 1, 0, 4'h0, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));

        // Scenario 3: zero settle and disabled timeout; other stages' done ignored
        add(3, 1,    0, 1, 0, 4'h0, z);
        add(3, 1,    1, 1, 0, 4'h0, z);
        add(3, 1,    2, 1, 0, 4'h0, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(3, 1,  500, 1, 0, 4'h2, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(3, 1,  501, 1, 0, 4'h2, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));
        add(3, 1, 1002, 1, 0, 4'h0, mk(4'h1, 4'h0, 0, 0, 0, 0, 0, 0));

        for (int s = 0; s < 4; s++) begin
            do_reset();
            base = cur;
            for (int i = 0; i < vecs.size(); i++) begin
                if (vecs[i].scn == s) begin
                    while ((cur - base) < vecs[i].cyc) tick();
                    if (vecs[i].dut == 0) begin
                        a_start = vecs[i].start; a_restart = vecs[i].restart; a_done = vecs[i].done[2:0];
                    end else begin
                        b_start = vecs[i].start; b_restart = vecs[i].restart; b_done = vecs[i].done;
                    end
                    sbq.push_back('{i, vecs[i].dut, vecs[i].exp});
                end
            end
            tick();
        end

        // Asynchronous reset in the middle of stage 1 SETTLE
        do_reset();
        a_start = 1'b1;
        repeat (8) tick();
        a_done = 3'b001;
        repeat (2) tick();
        #1;
        chk("pre_rst_state", obs_a, mk(4'h1, 4'h1, 0, 0, 0, 1, 1, 0));
        #1 rst = 1'b1;
        #1;
        chk("async_rst_clear", obs_a, z);
        tick();
        #1 chk("rst_hold_1", obs_a, z);
        tick();
        #1 chk("rst_hold_2", obs_a, z);
        a_start = 1'b0;
        a_done = '0;
        rst = 1'b0;
        tick();
        #1 chk("post_rst_idle", obs_a, z);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
        if (sbq.size() > 0) begin
            checks++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", sbq.size());
        end
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
